funnel_ctrl_param: RTL and testbench
====================================

// Module: funnel_ctrl_param
// PURPOSE
//  Parametrised handshake/select controller for a SLICES:1 word funnel. Splits one wide target
//  word (t_0) into SLICES narrow slices and issues them over 1..LANES initiator lanes per beat,
//  stepping a slice counter and driving the bit-reversed slice select to the funnel datapath.
//  Lane count (reduction) is runtime-configurable via a t_cfg handshake, applied only on word boundaries.
// PARAMETERS
//  SLICES      8   narrow slices per wide word; power of 2, >=2
//  LANES       4   max initiator lanes; power of 2, 1 <= LANES <= SLICES
//  SELW        $clog2(SLICES)  localparam, select/state width
//  KW          $clog2(LANES)+1 localparam, width of reduction-code field
//  RESET_MODE  8'h80  mode register value after reset (enabled, k=0 -> 1 lane)
// PORTS
//  clk        in   1        clock
//  reset      in   1        async reset, active high
//  t_0_req    in   1        wide word valid
//  t_0_ack    out  1        wide word consumed (pulses on final beat of word)
//  t_cfg_req  in   1        config write request
//  t_cfg_ack  out  1        config write accepted
//  cfg_mode   in   8        [7]=enable, [KW-1:0]=k; active lanes R = 2**k
//  i_req      out  LANES    per-lane slice valid
//  i_ack      in   LANES    per-lane slice accept
//  sel        out  SELW     slice select = bit-reverse(state)
//  mode_q     out  8        current mode register
//  busy       out  1        state != 0 (mid-word)
//  mode_err   out  1        mode_q[7] & (k > $clog2(LANES)); lane is treated as disabled
// BEHAVIOUR
//  Reset: state=0, mode_q=RESET_MODE; hence sel=0, busy=0, t_0_ack=0, i_req=0 (t_0_req low), t_cfg_ack=1.
//  en = mode_q[7] & ~mode_err; R = 1<<k; active mask m[j] = (j < R).
//  cfg_take = t_cfg_req & (state==0); t_cfg_ack = (state==0) (combinational).
//  On cfg_take: mode_q <= cfg_mode at next edge; i_req forced 0 that cycle, no progress (cfg wins at word boundary).
//  i_req[j] = t_0_req & en & m[j] & ~cfg_take; inactive lanes held 0.
//  all_ack = &(i_ack | ~m); progress = t_0_req & en & ~cfg_take & all_ack.
//  state_nxt = (state + R) mod SLICES (SELW-bit wrap); on progress state <= state_nxt.
//  last = (state_nxt == 0); t_0_ack = progress & last. Zero-latency: ack same cycle as final lane acks.
//  Partial lane acks (some active i_ack low) -> no progress, i_req held, state held; lanes must ack together.
//  R == SLICES: every progress is last; state stays 0; t_0_ack each accepted beat.
//  Beats per word = SLICES/R; sel sequence = bitrev(0), bitrev(R), bitrev(2R), ...
//  en=0 (disabled or mode_err): i_req=0, t_0_ack=0, state frozen; cfg still accepted if state==0.
//  Mode change only when state==0, so a word never mixes reduction ratios.
//  t_0_req drop mid-word: state held, resumes on next t_0_req (upstream must keep the same word).
//  Reset mid-word: state->0 asynchronously, partial word discarded, no t_0_ack issued.
//  i_ack bits of inactive lanes ignored.
// TESTING (SLICES=8, LANES=4)
//  Reset, t_0_req=1, i_ack=4'b0001 held -> sel 000,100,010,110,001,101,011,111; t_0_ack only on 8th beat; i_req=0001.
//  cfg k=2 (8'h82) at idle, i_ack=4'b1111 -> i_req=1111, sel 000 then 001, t_0_ack on 2nd beat, state back to 0.
//  k=1, i_ack=4'b0001 for 3 cycles then 4'b0011 -> state/sel frozen at 000 until both ack, then sel=010.
//  Mid-word (state=2, k=1) t_cfg_req=1 -> t_cfg_ack=0 until word completes; accepted cycle has i_req=0, new mode next cycle.
//  cfg 8'h83 (k=3>2) -> mode_err=1, i_req=0, t_0_ack=0; then cfg 8'h80 -> mode_err=0, single-lane resumes.
//  Assert reset at state=6 (k=0) -> sel=000, busy=0 immediately; no t_0_ack; next word starts at slice 0.

Source files
------------

// File: rtl/funnel_ctrl_param.sv
// Handshake/select controller for a SLICES:1 word funnel: steps a slice counter across
// 1..LANES lanes per beat and drives the bit-reversed slice select to the datapath.
module funnel_ctrl_param #(
  parameter int          SLICES     = 8,
  parameter int          LANES      = 4,
  parameter logic [7:0]  RESET_MODE = 8'h80,
  localparam int         SELW       = $clog2(SLICES),
  localparam int         KW         = $clog2(LANES) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t_0_req,
  output logic             t_0_ack,
  input  logic             t_cfg_req,
  output logic             t_cfg_ack,
  input  logic [7:0]       cfg_mode,
  output logic [LANES-1:0] i_req,
  input  logic [LANES-1:0] i_ack,
  output logic [SELW-1:0]  sel,
  output logic [7:0]       mode_q,
  output logic             busy,
  output logic             mode_err
);

  localparam logic [KW-1:0] KMAX = KW'($clog2(LANES));

  logic [SELW-1:0]  state_q, state_d, state_nxt;
  logic [7:0]       mode_d;
  logic [KW-1:0]    k;
  logic [SELW:0]    r_w;
  logic [LANES-1:0] mask;
  logic             en, idle, cfg_take, all_ack, progress, last;

  // Lane decode and handshake qualification
  always_comb begin
    k        = mode_q[KW-1:0];
    mode_err = mode_q[7] & (k > KMAX);
    en       = mode_q[7] & ~mode_err;
    r_w      = (SELW+1)'(1) << k;
    for (int j = 0; j < LANES; j++) begin
      mask[j] = ((SELW+1)'(j) < r_w);
    end
    idle      = (state_q == '0);
    cfg_take  = t_cfg_req & idle;
    all_ack   = &(i_ack | ~mask);
    progress  = t_0_req & en & ~cfg_take & all_ack;
    // R == SLICES wraps to +0, so every beat is the last one
    state_nxt = state_q + r_w[SELW-1:0];
    last      = (state_nxt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      mode_q  <= RESET_MODE;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (cfg_take) begin
      mode_d = cfg_mode;
    end else if (progress) begin
      state_d = state_nxt;
    end
  end

  always_comb begin
    t_cfg_ack = idle;
    t_0_ack   = progress & last;
    busy      = ~idle;
    i_req     = {LANES{t_0_req & en & ~cfg_take}} & mask;
    for (int b = 0; b < SELW; b++) begin
      sel[b] = state_q[SELW-1-b];
    end
  end

endmodule

// File: tb/tb_funnel_ctrl_param.sv
// Directed bench for funnel_ctrl_param with SLICES=8, LANES=4.
module tb_funnel_ctrl_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       t_0_req, t_0_ack, t_cfg_req, t_cfg_ack;
  logic [7:0] cfg_mode, mode_q;
  logic [3:0] i_req, i_ack;
  logic [2:0] sel;
  logic       busy, mode_err;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_sel [8];

  funnel_ctrl_param #(.SLICES(8), .LANES(4), .RESET_MODE(8'h80)) dut (
    .clk(clk), .reset(reset), .t_0_req(t_0_req), .t_0_ack(t_0_ack),
    .t_cfg_req(t_cfg_req), .t_cfg_ack(t_cfg_ack), .cfg_mode(cfg_mode),
    .i_req(i_req), .i_ack(i_ack), .sel(sel), .mode_q(mode_q),
    .busy(busy), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs change and checks happen 1-2 time units after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_sel = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    reset = 1'b1; t_0_req = 1'b0; t_cfg_req = 1'b0; cfg_mode = 8'h00; i_ack = 4'b0000;
    #12;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_t0ack", 32'(t_0_ack), 0);
    chk("rst_ireq", 32'(i_req), 0);
    chk("rst_cfgack", 32'(t_cfg_ack), 1);
    chk("rst_mode", 32'(mode_q), 32'h80);
    reset = 1'b0;
    cyc();

    // Single lane, eight beats per word
    t_0_req = 1'b1; i_ack = 4'b0001;
    for (int b = 0; b < 8; b++) begin
      #1;
      chk("k0_sel", 32'(sel), 32'(exp_sel[b]));
      chk("k0_ireq", 32'(i_req), 32'h1);
      chk("k0_t0ack", 32'(t_0_ack), (b == 7) ? 1 : 0);
      cyc();
    end
    chk("k0_done_busy", 32'(busy), 0);

    // Config at idle wins over a pending word
    t_cfg_req = 1'b1; cfg_mode = 8'h82; #1;
    chk("cfg_ack_idle", 32'(t_cfg_ack), 1);
    chk("cfg_ireq0", 32'(i_req), 0);
    chk("cfg_t0ack0", 32'(t_0_ack), 0);
    cyc();
    chk("cfg_mode82", 32'(mode_q), 32'h82);
    chk("cfg_nostep", 32'(busy), 0);

    // Four lanes: two beats per word
    t_cfg_req = 1'b0; i_ack = 4'b1111; #1;
    chk("k2_ireq", 32'(i_req), 32'hF);
    chk("k2_sel0", 32'(sel), 0);
    chk("k2_ack0", 32'(t_0_ack), 0);
    cyc(); #1;
    chk("k2_sel1", 32'(sel), 1);
    chk("k2_ack1", 32'(t_0_ack), 1);
    cyc();
    chk("k2_idle", 32'(busy), 0);

    // Two lanes with partial acks
    t_0_req = 1'b0; t_cfg_req = 1'b1; cfg_mode = 8'h81;
    cyc();
    t_cfg_req = 1'b0; t_0_req = 1'b1; i_ack = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("k1_part_sel", 32'(sel), 0);
      chk("k1_part_ireq", 32'(i_req), 32'h3);
      chk("k1_part_ack", 32'(t_0_ack), 0);
      cyc();
    end
    i_ack = 4'b0011;
    cyc(); #1;
    chk("k1_step_sel", 32'(sel), 32'h2);
    chk("k1_step_busy", 32'(busy), 1);

    // Config requested mid-word waits for the word to finish
    t_cfg_req = 1'b1; cfg_mode = 8'h82;
    chk("mid_cfgack_s2", 32'(t_cfg_ack), 0);
    chk("mid_ireq_s2", 32'(i_req), 32'h3);
    cyc(); #1;
    chk("mid_sel_s4", 32'(sel), 32'h1);
    chk("mid_cfgack_s4", 32'(t_cfg_ack), 0);
    cyc(); #1;
    chk("mid_sel_s6", 32'(sel), 32'h3);
    chk("mid_cfgack_s6", 32'(t_cfg_ack), 0);
    chk("mid_t0ack_s6", 32'(t_0_ack), 1);
    cyc(); #1;
    chk("mid_cfgack_s0", 32'(t_cfg_ack), 1);
    chk("mid_ireq_take", 32'(i_req), 0);
    chk("mid_mode_old", 32'(mode_q), 32'h81);
    cyc(); #1;
    chk("mid_mode_new", 32'(mode_q), 32'h82);
    chk("mid_busy", 32'(busy), 0);

    // Out-of-range reduction code disables the lanes
    t_0_req = 1'b0; cfg_mode = 8'h83;
    cyc();
    t_cfg_req = 1'b0; t_0_req = 1'b1; i_ack = 4'b1111; #1;
    chk("err_flag", 32'(mode_err), 1);
    chk("err_ireq", 32'(i_req), 0);
    chk("err_t0ack", 32'(t_0_ack), 0);
    cyc();
    chk("err_frozen", 32'(busy), 0);
    t_cfg_req = 1'b1; cfg_mode = 8'h80;
    cyc();
    t_cfg_req = 1'b0; i_ack = 4'b1001; #1;
    chk("rec_flag", 32'(mode_err), 0);
    chk("rec_ireq", 32'(i_req), 32'h1);
    chk("rec_sel", 32'(sel), 0);

    // Reset in the middle of a word at state 6
    for (int c = 0; c < 6; c++) cyc();
    #1;
    chk("pre_rst_sel", 32'(sel), 32'h3);
    reset = 1'b1; #1;
    chk("mid_rst_sel", 32'(sel), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_t0ack", 32'(t_0_ack), 0);
    reset = 1'b0; #1;
    chk("post_rst_sel0", 32'(sel), 0);
    cyc(); #1;
    chk("post_rst_sel1", 32'(sel), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
